// File: rtl/axil_cmd_master.sv
// axil_cmd_master: AXI4-Lite master that drains a small command FIFO
// and issues one single-beat read or write at a time on the bus,
// returning BRESP or RDATA/RRESP on a response handshake port.
//
// Optional build macro: AXIM_TIMEOUT_EN
//   When defined, a per-state watchdog abandons a stuck transaction after
//   TIMEOUT_CYCLES cycles, pulses timeout_o and reports rsp_resp = 2'b11.
//   When undefined, there is no watchdog and no timeout_o port.

module axil_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rnw,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_rnw,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,

  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,

  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,

  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,

  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,

  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
`ifdef AXIM_TIMEOUT_EN
  ,
  output logic                timeout_o
`endif
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W;

  // Elaboration-time parameter sanity checks
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("axil_cmd_master: ADDR_W must be at least 2");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axil_cmd_master: DATA_W must be 32 or 64");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axil_cmd_master: CMD_DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  state_t state_q, state_d;

  // Command FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic               head_rnw;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;
  logic [STRB_W-1:0]  head_wstrb;

  // Registered bus and response outputs
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_rnw_q, rsp_rnw_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;

`ifdef AXIM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    to_count_q, to_count_d;
  logic               timeout_q, timeout_d;
`endif

  assign fifo_full  = (fifo_count == CNT_W'(CMD_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = ready_en & ~fifo_full;
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == IDLE) & ~fifo_empty;

  assign {head_rnw, head_addr, head_wdata, head_wstrb} = fifo_mem[rd_ptr];

  // FIFO payload write; storage needs no reset because count guards it
  always_ff @(posedge M_AXI_ACLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb};
    end
  end

  // FIFO pointers, occupancy, and the post-reset enable for cmd_ready
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State and registered-output flops for the transaction engine
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rnw_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef AXIM_TIMEOUT_EN
      to_count_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rnw_q   <= rsp_rnw_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXIM_TIMEOUT_EN
      to_count_q  <= to_count_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state and next-output logic; every output is registered so no
  // input reaches an output combinationally
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rnw_d   = rsp_rnw_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXIM_TIMEOUT_EN
    to_count_d  = '0;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_rnw) begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
            araddr_d  = head_addr;
          end else begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = head_addr;
            wdata_d   = head_wdata;
            wstrb_d   = head_wstrb;
          end
        end
      end

      WADDR: begin
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end

      WRESP: begin
        if (M_AXI_BVALID) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
        end
      end

      RADDR: begin
        if (M_AXI_ARREADY) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      RDATA: begin
        if (M_AXI_RVALID) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = 1'b1;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef AXIM_TIMEOUT_EN
    if ((state_d == state_q) &&
        (state_q == WADDR || state_q == WRESP ||
         state_q == RADDR || state_q == RDATA)) begin
      if (to_count_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RSP;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rnw_d   = (state_q == RADDR) || (state_q == RDATA);
        rsp_rdata_d = '0;
        rsp_resp_d  = 2'b11;
        timeout_d   = 1'b1;
      end else begin
        to_count_d = to_count_q + TO_W'(1);
      end
    end
`endif
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rnw   = rsp_rnw_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

`ifdef AXIM_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule
